filter_read_sequencer: RTL and testbench

//  Sequences reads out of the circular filter scratchpad for the PE datapath.

---
 rtl/filter_read_sequencer.sv | 96 +++++++++
 tb/tb_filter_read_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/filter_read_sequencer.sv
// filter_read_sequencer: replays each circular-scratchpad filter once per window, then releases it
module filter_read_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_filters,
  input  logic [CNT_WIDTH-1:0]  num_windows,
  input  logic [ADDR_WIDTH-1:0] filt_len,
  input  logic                  filt_ready,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [ADDR_WIDTH-1:0] end_ptr,
  output logic                  ep_valid,
  output logic                  filt_last,
  output logic                  window_done,
  output logic                  filt_release,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_REL, S_DONE} state_t;
  localparam logic [ADDR_WIDTH:0] DEP = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] C1 = CNT_WIDTH'(1);
  state_t state;
  logic [ADDR_WIDTH-1:0] base, len_q;
  logic [CNT_WIDTH-1:0] nf_q, nw_q, filt_cnt, win_cnt;
  function automatic logic [ADDR_WIDTH-1:0] wrap(input logic [ADDR_WIDTH:0] s);
    return (s >= DEP) ? ADDR_WIDTH'(s - DEP) : s[ADDR_WIDTH-1:0];
  endfunction
  assign ep_valid  = rd_valid & rd_ready;
  assign filt_last = ep_valid & (read_addr == end_ptr);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      base         <= '0;
      len_q        <= '0;
      nf_q         <= '0;
      nw_q         <= '0;
      filt_cnt     <= '0;
      win_cnt      <= '0;
      rd_valid     <= 1'b0;
      read_addr    <= '0;
      end_ptr      <= '0;
      window_done  <= 1'b0;
      filt_release <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      filt_release <= 1'b0;
      window_done  <= filt_last;
      done         <= state == S_DONE;
      case (state)
        S_IDLE: if (start) begin
          nf_q     <= num_filters;
          nw_q     <= num_windows;
          len_q    <= filt_len;
          filt_cnt <= '0;
          busy     <= 1'b1;
          state    <= (num_filters == '0 || num_windows == '0 || filt_len == '0) ? S_DONE : S_WAIT;
        end
        S_WAIT: if (filt_ready) begin
          end_ptr   <= wrap({1'b0, base} + {1'b0, len_q} - ONE);
          read_addr <= base;
          win_cnt   <= '0;
          rd_valid  <= 1'b1;
          state     <= S_READ;
        end
        S_READ: if (ep_valid) begin
          if (!filt_last) read_addr <= wrap({1'b0, read_addr} + ONE);
          else if (win_cnt != nw_q - C1) begin
            read_addr <= base;
            win_cnt   <= win_cnt + C1;
          end else begin
            rd_valid     <= 1'b0;
            filt_release <= 1'b1;
            state        <= S_REL;
          end
        end
        S_REL: begin
          base     <= wrap({1'b0, end_ptr} + ONE);
          filt_cnt <= filt_cnt + C1;
          state    <= (filt_cnt == nf_q - C1) ? S_DONE : S_WAIT;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_filter_read_sequencer.sv
// tb_filter_read_sequencer: directed checks of the filter read sequencer at DEPTH 256 and 16
module tb_filter_read_sequencer;
  logic clk = 0, rst = 1, start = 0, filt_ready = 0, rd_ready = 0;
  logic [7:0] num_filters = 0, num_windows = 0, filt_len = 0;
  logic d1_rd_valid, d1_ep_valid, d1_filt_last, d1_window_done, d1_filt_release, d1_busy, d1_done;
  logic [7:0] d1_read_addr, d1_end_ptr;
  logic d2_rd_valid, d2_ep_valid, d2_filt_last, d2_window_done, d2_filt_release, d2_busy, d2_done;
  logic [7:0] d2_read_addr, d2_end_ptr;
  int passed = 0, failed = 0, total = 0;
  always #5 clk = ~clk;
  filter_read_sequencer dut1 (
    .clk(clk), .rst(rst), .start(start), .num_filters(num_filters), .num_windows(num_windows),
    .filt_len(filt_len), .filt_ready(filt_ready), .rd_ready(rd_ready), .rd_valid(d1_rd_valid),
    .read_addr(d1_read_addr), .end_ptr(d1_end_ptr), .ep_valid(d1_ep_valid), .filt_last(d1_filt_last),
    .window_done(d1_window_done), .filt_release(d1_filt_release), .busy(d1_busy), .done(d1_done));
  filter_read_sequencer #(.ADDR_WIDTH(8), .DEPTH(16), .CNT_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .start(start), .num_filters(num_filters), .num_windows(num_windows),
    .filt_len(filt_len), .filt_ready(filt_ready), .rd_ready(rd_ready), .rd_valid(d2_rd_valid),
    .read_addr(d2_read_addr), .end_ptr(d2_end_ptr), .ep_valid(d2_ep_valid), .filt_last(d2_filt_last),
    .window_done(d2_window_done), .filt_release(d2_filt_release), .busy(d2_busy), .done(d2_done));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic start_run(input int nf, input int nw, input int fl);
    num_filters = 8'(nf);
    num_windows = 8'(nw);
    filt_len    = 8'(fl);
    start = 1;
    tick();
    start = 0;
  endtask
  function automatic logic [31:0] d1_outs();
    return {d1_rd_valid, d1_ep_valid, d1_filt_last, d1_window_done, d1_filt_release, d1_busy, d1_done,
            d1_read_addr, d1_end_ptr};
  endfunction
  logic [7:0] t2a [4] = '{8'd14, 8'd15, 8'd0, 8'd1};
  logic rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    int exp_addr;
    tick();
    chk("reset_outputs", d1_outputs_ok(), 32'd0);
    tick();
    rst = 0;
    filt_ready = 1;
    rd_ready = 1;
    tick();
    start_run(1, 1, 14);
    chk("wait_after_start", {d1_busy, d1_rd_valid}, 2'b10);
    tick();
    for (int i = 0; i < 14; i++) begin
      chk("prelude_addr", d2_read_addr, i);
      tick();
    end
    chk("prelude_release", d2_filt_release, 1);
    tick();
    tick();
    chk("prelude_done", {d2_done, d2_busy}, 2'b10);
    start_run(1, 1, 4);
    tick();
    chk("wrap_end_ptr", d2_end_ptr, 1);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", d2_read_addr, t2a[i]);
      chk("wrap_filt_last", d2_filt_last, i == 3);
      tick();
    end
    chk("wrap_release", d2_filt_release, 1);
    tick();
    tick();
    start_run(1, 1, 16);
    tick();
    chk("full_buffer_base", d2_read_addr, 2);
    chk("full_buffer_end_ptr", d2_end_ptr, 1);
    rst = 1;
    tick();
    chk("reset_state", d1_outputs_ok(), 32'd0);
    rst = 0;
    tick();
    start_run(1, 2, 4);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("basic_addr", d1_read_addr, i % 4);
      chk("basic_filt_last", d1_filt_last, (i % 4) == 3);
      chk("basic_no_release", d1_filt_release, 0);
      if (i == 4) chk("basic_window_done", d1_window_done, 1);
      tick();
    end
    chk("basic_release", {d1_filt_release, d1_rd_valid, d1_busy}, 3'b101);
    tick();
    chk("basic_done_early", d1_done, 0);
    tick();
    chk("basic_done", {d1_done, d1_busy}, 2'b10);
    start_run(1, 1, 3);
    tick();
    exp_addr = 4;
    for (int k = 0; k < 7; k++) begin
      rd_ready = rdy[k];
      #1;
      chk("stall_addr", d1_read_addr, exp_addr);
      chk("stall_end_ptr", d1_end_ptr, 6);
      chk("stall_rd_valid", d1_rd_valid, 1);
      chk("stall_ep_valid", d1_ep_valid, rdy[k]);
      if (rdy[k]) exp_addr++;
      tick();
    end
    chk("stall_release", d1_filt_release, 1);
    rd_ready = 1;
    tick();
    tick();
    start_run(2, 1, 2);
    tick();
    chk("fr_first_addr", d1_read_addr, 7);
    tick();
    chk("fr_second_addr", {d1_read_addr, d1_filt_last}, {8'd8, 1'b1});
    tick();
    filt_ready = 0;
    chk("fr_release", d1_filt_release, 1);
    tick();
    for (int j = 0; j < 10; j++) begin
      chk("fr_wait_idle_read", {d1_rd_valid, d1_busy}, 2'b01);
      tick();
    end
    filt_ready = 1;
    tick();
    chk("fr_resume", {d1_rd_valid, d1_read_addr, d1_end_ptr}, {1'b1, 8'd9, 8'd10});
    tick();
    tick();
    chk("fr_release2", d1_filt_release, 1);
    tick();
    tick();
    chk("fr_done", d1_done, 1);
    start_run(1, 0, 4);
    chk("degen_not_yet", {d1_done, d1_rd_valid}, 2'b00);
    tick();
    chk("degen_done", {d1_done, d1_rd_valid, d1_busy}, 3'b100);
    start_run(1, 1, 2);
    tick();
    chk("busy_start_addr", d1_read_addr, 11);
    num_filters = 5;
    filt_len = 8;
    start = 1;
    tick();
    start = 0;
    chk("busy_start_ignored", {d1_read_addr, d1_end_ptr}, {8'd12, 8'd12});
    tick();
    chk("busy_start_release", d1_filt_release, 1);
    tick();
    tick();
    chk("busy_start_done", d1_done, 1);
    rst = 1;
    tick();
    rst = 0;
    start_run(1, 1, 8);
    tick();
    tick();
    tick();
    chk("abort_addr", d1_read_addr, 2);
    rst = 1;
    #1;
    chk("abort_outputs", d1_outputs_ok(), 32'd0);
    tick();
    rst = 0;
    start_run(1, 1, 4);
    tick();
    chk("after_abort", {d1_read_addr, d1_rd_valid, d1_busy}, {8'd0, 1'b1, 1'b1});
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  function automatic logic [31:0] d1_outputs_ok();
    return d1_outs();
  endfunction
endmodule
